cruise_counter_ctrl: RTL and testbench

//  Cruise-control sequencer for the setpoint up/down counter (three_bit_counter datapath).

---
 rtl/cruise_counter_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_cruise_counter_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cruise_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cruise_counter_ctrl
// Brief    : Cruise-control sequencer that drives the setpoint up/down counter.
// Revision : 1.0
// ============================================================================
module cruise_counter_ctrl #(
   parameter int WIDTH    = 3,
   parameter int MIN_SPD  = 1,
   parameter int MAX_SPD  = 7,
   parameter int STEP_DIV = 4
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             on_off,
   input  logic             set_btn,
   input  logic             resume_btn,
   input  logic             accel_btn,
   input  logic             decel_btn,
   input  logic             brake,
   input  logic             cancel,
   input  logic [WIDTH-1:0] speed_in,
   input  logic [WIDTH-1:0] cnt_value,
   output logic             cnt_enable,
   output logic             cnt_mode,
   output logic             cnt_load,
   output logic [WIDTH-1:0] cnt_load_value,
   output logic             cnt_clear,
   output logic             cruise_active,
   output logic [2:0]       state
);

   localparam int                 c_tmr_w     = $clog2(STEP_DIV);
   localparam logic [WIDTH-1:0]   c_min       = WIDTH'(MIN_SPD);
   localparam logic [WIDTH-1:0]   c_max       = WIDTH'(MAX_SPD);
   localparam logic [c_tmr_w-1:0] c_step_last = c_tmr_w'(STEP_DIV - 1);

   typedef enum logic [2:0] {
      S_OFF     = 3'd0,
      S_IDLE    = 3'd1,
      S_CRUISE  = 3'd2,
      S_ACCEL   = 3'd3,
      S_DECEL   = 3'd4,
      S_STANDBY = 3'd5
   } state_t;

   state_t             r_state;
   logic               r_set_d;
   logic               r_resume_d;
   logic [c_tmr_w-1:0] r_tmr;
   logic               r_enable;
   logic               r_mode;
   logic               r_load;
   logic [WIDTH-1:0]   r_load_value;
   logic               r_clear;
   logic               r_active;

   state_t             w_nxt;
   logic [c_tmr_w-1:0] w_tmr;
   logic               w_enable;
   logic               w_mode;
   logic               w_load;
   logic [WIDTH-1:0]   w_load_value;
   logic               w_clear;
   logic               w_set_e;
   logic               w_res_e;
   logic               w_kill;
   logic               w_spd_ok;
   logic [WIDTH-1:0]   w_clamped;
   logic               w_is_acc;
   logic               w_leave;
   logic               w_room;

   assign w_set_e   = set_btn & ~r_set_d;
   assign w_res_e   = resume_btn & ~r_resume_d;
   assign w_kill    = brake | cancel;
   assign w_spd_ok  = (speed_in >= c_min);
   assign w_clamped = (speed_in > c_max) ? c_max : speed_in;
   assign w_is_acc  = (r_state == S_ACCEL);
   // Stepping stops when the active button drops or the opposite one joins it.
   assign w_leave   = w_is_acc ? (~accel_btn | decel_btn) : (~decel_btn | accel_btn);
   assign w_room    = w_is_acc ? (cnt_value < c_max) : (cnt_value > c_min);

   always_comb begin
      w_nxt        = r_state;
      w_tmr        = '0;
      w_enable     = 1'b0;
      w_mode       = r_mode;
      w_load       = 1'b0;
      w_load_value = r_load_value;
      w_clear      = 1'b0;
      if (!on_off) begin
         w_nxt   = S_OFF;
         w_clear = (r_state != S_OFF);
      end else begin
         case (r_state)
            S_OFF: w_nxt = S_IDLE;
            S_IDLE: begin
               if (!w_kill && w_set_e && w_spd_ok) begin
                  w_nxt        = S_CRUISE;
                  w_load       = 1'b1;
                  w_load_value = w_clamped;
               end
            end
            S_CRUISE: begin
               if (w_kill) begin
                  w_nxt = S_STANDBY;
               end else if (w_set_e && w_spd_ok) begin
                  w_load       = 1'b1;
                  w_load_value = w_clamped;
               end else if (accel_btn && !decel_btn) begin
                  w_nxt = S_ACCEL;
               end else if (decel_btn && !accel_btn) begin
                  w_nxt = S_DECEL;
               end
            end
            S_ACCEL, S_DECEL: begin
               if (w_kill) begin
                  w_nxt = S_STANDBY;
               end else if (w_set_e && w_spd_ok) begin
                  w_nxt        = S_CRUISE;
                  w_load       = 1'b1;
                  w_load_value = w_clamped;
               end else if (w_leave) begin
                  w_nxt = S_CRUISE;
               end else if (r_tmr == c_step_last) begin
                  // Timer wraps even when saturated so cadence is kept.
                  if (w_room) begin
                     w_enable = 1'b1;
                     w_mode   = w_is_acc;
                  end
               end else begin
                  w_tmr = r_tmr + 1'b1;
               end
            end
            S_STANDBY: begin
               if (!w_kill) begin
                  if (w_set_e) begin
                     if (w_spd_ok) begin
                        w_nxt        = S_CRUISE;
                        w_load       = 1'b1;
                        w_load_value = w_clamped;
                     end
                  end else if (w_res_e) begin
                     w_nxt = S_CRUISE;
                  end
               end
            end
            default: w_nxt = S_OFF;
         endcase
      end
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_state      <= S_OFF;
         r_set_d      <= 1'b0;
         r_resume_d   <= 1'b0;
         r_tmr        <= '0;
         r_enable     <= 1'b0;
         r_mode       <= 1'b0;
         r_load       <= 1'b0;
         r_load_value <= '0;
         r_clear      <= 1'b0;
         r_active     <= 1'b0;
      end else begin
         r_state      <= w_nxt;
         r_set_d      <= set_btn;
         r_resume_d   <= resume_btn;
         r_tmr        <= w_tmr;
         r_enable     <= w_enable;
         r_mode       <= w_mode;
         r_load       <= w_load;
         r_load_value <= w_load_value;
         r_clear      <= w_clear;
         r_active     <= (w_nxt == S_CRUISE) || (w_nxt == S_ACCEL) || (w_nxt == S_DECEL);
      end
   end

   assign cnt_enable     = r_enable;
   assign cnt_mode       = r_mode;
   assign cnt_load       = r_load;
   assign cnt_load_value = r_load_value;
   assign cnt_clear      = r_clear;
   assign cruise_active  = r_active;
   assign state          = r_state;

endmodule
`default_nettype wire

// File: tb/tb_cruise_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cruise_counter_ctrl
// Brief    : Directed vector table plus multi-cycle sequences for the sequencer.
// Revision : 1.0
// ============================================================================
module tb_cruise_counter_ctrl;

   logic       clk = 1'b0;
   logic       clear_n;
   logic       on_off, set_btn, resume_btn, accel_btn, decel_btn, brake, cancel;
   logic [2:0] speed_in, cnt_value;
   logic       cnt_enable, cnt_mode, cnt_load, cnt_clear, cruise_active;
   logic [2:0] cnt_load_value, state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cruise_counter_ctrl #(
      .WIDTH(3), .MIN_SPD(1), .MAX_SPD(7), .STEP_DIV(4)
   ) dut (
      .clk(clk), .clear_n(clear_n), .on_off(on_off), .set_btn(set_btn),
      .resume_btn(resume_btn), .accel_btn(accel_btn), .decel_btn(decel_btn),
      .brake(brake), .cancel(cancel), .speed_in(speed_in), .cnt_value(cnt_value),
      .cnt_enable(cnt_enable), .cnt_mode(cnt_mode), .cnt_load(cnt_load),
      .cnt_load_value(cnt_load_value), .cnt_clear(cnt_clear),
      .cruise_active(cruise_active), .state(state)
   );

   // btn = {on_off,set,resume,accel,decel,brake,cancel}; ex = {en,mode,load,clear,active}
   typedef struct {
      logic [6:0] btn;
      logic [2:0] spd;
      logic [4:0] ex;
      logic [2:0] lv;
      logic [2:0] st;
   } vec_t;

   vec_t tbl[21];

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, a, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [4:0] ex,
                          input logic [2:0] lv, input logic [2:0] st);
      chk({tag, ".en"},    {31'd0, cnt_enable},    {31'd0, ex[4]});
      chk({tag, ".mode"},  {31'd0, cnt_mode},      {31'd0, ex[3]});
      chk({tag, ".load"},  {31'd0, cnt_load},      {31'd0, ex[2]});
      chk({tag, ".clr"},   {31'd0, cnt_clear},     {31'd0, ex[1]});
      chk({tag, ".act"},   {31'd0, cruise_active}, {31'd0, ex[0]});
      chk({tag, ".lv"},    {29'd0, cnt_load_value}, {29'd0, lv});
      chk({tag, ".state"}, {29'd0, state},         {29'd0, st});
   endtask

   initial begin
      int n, first, bad;

      tbl[0]  = '{7'b1000000, 3'd5, 5'b00000, 3'd0, 3'd1};
      tbl[1]  = '{7'b1100000, 3'd5, 5'b00101, 3'd5, 3'd2};
      tbl[2]  = '{7'b1100000, 3'd5, 5'b00001, 3'd5, 3'd2};
      tbl[3]  = '{7'b1000000, 3'd5, 5'b00001, 3'd5, 3'd2};
      tbl[4]  = '{7'b1000010, 3'd5, 5'b00000, 3'd5, 3'd5};
      tbl[5]  = '{7'b1010010, 3'd5, 5'b00000, 3'd5, 3'd5};
      tbl[6]  = '{7'b1010000, 3'd5, 5'b00000, 3'd5, 3'd5};
      tbl[7]  = '{7'b1000000, 3'd5, 5'b00000, 3'd5, 3'd5};
      tbl[8]  = '{7'b1010000, 3'd5, 5'b00001, 3'd5, 3'd2};
      tbl[9]  = '{7'b1100000, 3'd7, 5'b00101, 3'd7, 3'd2};
      tbl[10] = '{7'b1000001, 3'd7, 5'b00000, 3'd7, 3'd5};
      tbl[11] = '{7'b1100000, 3'd0, 5'b00000, 3'd7, 3'd5};
      tbl[12] = '{7'b1000000, 3'd3, 5'b00000, 3'd7, 3'd5};
      tbl[13] = '{7'b1100000, 3'd3, 5'b00101, 3'd3, 3'd2};
      tbl[14] = '{7'b0000000, 3'd3, 5'b00010, 3'd3, 3'd0};
      tbl[15] = '{7'b0000000, 3'd3, 5'b00000, 3'd3, 3'd0};
      tbl[16] = '{7'b1000000, 3'd3, 5'b00000, 3'd3, 3'd1};
      tbl[17] = '{7'b1100000, 3'd0, 5'b00000, 3'd3, 3'd1};
      tbl[18] = '{7'b1100000, 3'd4, 5'b00000, 3'd3, 3'd1};
      tbl[19] = '{7'b1000000, 3'd4, 5'b00000, 3'd3, 3'd1};
      tbl[20] = '{7'b1100000, 3'd4, 5'b00101, 3'd4, 3'd2};

      clear_n = 1'b0;
      {on_off, set_btn, resume_btn, accel_btn, decel_btn, brake, cancel} = 7'b0;
      speed_in = 3'd5;
      cnt_value = 3'd5;
      #1;
      chk_all("reset", 5'b00000, 3'd0, 3'd0);
      tick();
      #2 clear_n = 1'b1;
      tick();
      chk_all("post_reset", 5'b00000, 3'd0, 3'd0);

      for (int i = 0; i < 21; i++) begin
         {on_off, set_btn, resume_btn, accel_btn, decel_btn, brake, cancel} = tbl[i].btn;
         speed_in = tbl[i].spd;
         tick();
         chk_all($sformatf("v%0d", i), tbl[i].ex, tbl[i].lv, tbl[i].st);
      end

      // Accel from setpoint 5 for 12 cycles after entry: steps land on cycles 4, 8, 12.
      set_btn = 1'b0; cnt_value = 3'd5; accel_btn = 1'b1;
      tick();
      chk("acc.entry", {29'd0, state}, 32'd3);
      n = 0; first = 0; bad = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (cnt_enable) begin
            n++;
            if (first == 0) first = i;
            if (!cnt_mode || cnt_load) bad++;
         end
      end
      chk("acc.pulses", n, 3);
      chk("acc.first", first, 4);
      chk("acc.mode_excl", bad, 0);
      accel_btn = 1'b0;
      tick();
      chk("acc.release", {29'd0, state}, 32'd2);

      // Saturated at top: no steps.
      cnt_value = 3'd7; accel_btn = 1'b1;
      tick();
      n = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (cnt_enable) n++;
      end
      chk("acc_sat.pulses", n, 0);
      chk("acc_sat.state", {29'd0, state}, 32'd3);
      accel_btn = 1'b0;
      tick();

      // Floored at bottom, then room again: one down-step within the next four cycles.
      cnt_value = 3'd1; decel_btn = 1'b1;
      tick();
      chk("dec.entry", {29'd0, state}, 32'd4);
      n = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (cnt_enable) n++;
      end
      chk("dec_floor.pulses", n, 0);
      cnt_value = 3'd5;
      n = 0; bad = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (cnt_enable) begin
            n++;
            if (cnt_mode) bad++;
         end
      end
      chk("dec.pulses", n, 1);
      chk("dec.mode", bad, 0);
      decel_btn = 1'b0;
      tick();
      chk("dec.release", {29'd0, state}, 32'd2);
      chk("dec.mode_hold", {31'd0, cnt_mode}, 32'd0);

      accel_btn = 1'b1; decel_btn = 1'b1;
      tick();
      chk("both.state", {29'd0, state}, 32'd2);
      accel_btn = 1'b0; decel_btn = 1'b0;

      // Off from CRUISE: exactly one clear; then held set in IDLE loads once.
      on_off = 1'b0;
      n = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (cnt_clear) n++;
      end
      chk("off.clears", n, 1);
      chk("off.state", {29'd0, state}, 32'd0);
      on_off = 1'b1;
      tick();
      chk("on.state", {29'd0, state}, 32'd1);
      speed_in = 3'd5; set_btn = 1'b1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (cnt_load) n++;
      end
      chk("set_held.loads", n, 1);
      chk("set_held.state", {29'd0, state}, 32'd2);
      chk("set_held.lv", {29'd0, cnt_load_value}, 32'd5);
      set_btn = 1'b0;

      // Reset asserted while a step pulse is on the outputs.
      cnt_value = 3'd5; accel_btn = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) tick();
      tick();
      chk("mid.en_before", {31'd0, cnt_enable}, 32'd1);
      #2 clear_n = 1'b0;
      #1;
      chk_all("mid_reset", 5'b00000, 3'd0, 3'd0);
      accel_btn = 1'b0;
      tick();
      chk("mid_reset.hold", {29'd0, state}, 32'd0);
      #2 clear_n = 1'b1;
      tick();
      chk("mid_reset.idle", {29'd0, state}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
